vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Generates 640x480@60 Hz VGA raster timing from the 50 MHz system clock. Produces the pixel clock, the current pixel coordinates `DrawX`/`DrawY` that feed the color mapper, and the sync and blank strobes to the VGA DAC. Sync and blank are delayed by a configurable number of pixel periods so they line up with the latency of the cover-art and sprite ROM color path.

## Interface
- `H_VISIBLE`, default 640: visible pixels per line.
- `H_FP`, default 16: horizontal front porch, in pixels.
- `H_SYNC`, default 96: horizontal sync width, in pixels.
- `H_BP`, default 48: horizontal back porch. H_TOTAL = 800.
- `V_VISIBLE`, default 480: visible lines.
- `V_FP`, default 10: vertical front porch, in lines.
- `V_SYNC`, default 2: vertical sync width, in lines.
- `V_BP`, default 33: vertical back porch. V_TOTAL = 525.
- `PIPE_DEPTH`, default 2: pixel-period delay of `hs`/`vs`/`blank` relative to `DrawX`/`DrawY`. Legal range 0..4.
- `Clk` in 1: 50 MHz system clock. One clock domain.
- `Reset_n` in 1: asynchronous, active-low reset.
- `pixel_clk` out 1: `Clk`/2, drives `VGA_CLK`.
- `DrawX` out 10: current horizontal count, 0..H_TOTAL-1.
- `DrawY` out 10: current vertical count, 0..V_TOTAL-1.
- `hs` out 1: horizontal sync, active-low, delayed.
- `vs` out 1: vertical sync, active-low, delayed.
- `blank` out 1: display enable, 1 = visible, delayed. Drives `VGA_BLANK_N`.
- `sync` out 1: constant 0 (`VGA_SYNC_N` unused).
- `frame_start` out 1: one-`Clk` pulse at the start of each frame.

## Operation
- All outputs are registered. Every flop is cleared asynchronously when `Reset_n` = 0.
- Reset values:
  - `pixel_clk` = 0, `DrawX` = 0, `DrawY` = 0.
  - `hs` = 1, `vs` = 1, `blank` = 0, `sync` = 0, `frame_start` = 0.
  - All delay-stage flops take their idle values: sync 1, blank 0.
- `pixel_clk` toggles on every `Clk` edge. Internal `pix_ce` equals the registered `pixel_clk` value.
- On a `Clk` edge with `pix_ce` = 1 (advance edge):
  - `DrawX` increments.
  - At H_TOTAL-1, `DrawX` wraps to 0 and `DrawY` increments.
  - At (H_TOTAL-1, V_TOTAL-1), both wrap to 0.
  - No other `Clk` edge changes the counters.
- Raw strobes are decoded from the counter values:
  - `hs_raw` = 0 when H_VISIBLE+H_FP ≤ `DrawX` < H_VISIBLE+H_FP+H_SYNC, i.e. 656..751.
  - `vs_raw` = 0 when `DrawY` is 490..491.
  - `blank_raw` = 1 when `DrawX` < 640 and `DrawY` < 480.
- Delay line: a shift register PIPE_DEPTH stages deep, advanced only on advance edges.
  - Outputs equal the raw values of the pixel PIPE_DEPTH pixel periods earlier.
  - With PIPE_DEPTH = 0, the outputs track the same pixel as `DrawX`/`DrawY`. They are still registered, updating on the same edge as the counters.
- `frame_start`: high for exactly the one `Clk` cycle that follows the advance edge on which the counters wrap to (0,0).
- Delayed strobes continue across the frame wrap without a gap, since the shift register is never flushed except by reset.

## Timing
- One pixel period = 2 `Clk`.
- Line period = 1600 `Clk`; frame period = 840000 `Clk`.
- After `Reset_n` is released, the first `Clk` edge sets `pixel_clk` = 1. The second edge is the first advance edge, taking `DrawX` from 0 to 1.
- `hs` is low for 192 `Clk` per line. `vs` is low for 3200 `Clk` per frame.
- Reset asserted mid-frame: outputs return to reset values immediately, without waiting for `Clk`. Timing restarts from (0,0) with no residual pulse from the delay line.
- `DrawX`/`DrawY` stay in range at all times. Values ≥ H_TOTAL or ≥ V_TOTAL are never produced.

## Test plan
- Reset check: hold `Reset_n` = 0 for 5 `Clk`, then release.
  - During reset: `hs` = `vs` = 1, `blank` = 0, `DrawX` = `DrawY` = 0, `pixel_clk` = 0.
  - After release: `DrawX` = 1 after the 2nd edge and 2 after the 4th edge.
- Line timing with PIPE_DEPTH = 0: falling edges of `hs` are exactly 1600 `Clk` apart.
  - `hs` falls on the edge where `DrawX` becomes 656 and rises where `DrawX` becomes 752.
- Frame timing: consecutive `frame_start` pulses are exactly 840000 `Clk` apart, each exactly 1 `Clk` wide, each coincident with `DrawX` = 0 and `DrawY` = 0.
  - `vs` is low only while `DrawY` is 490..491, i.e. 3200 `Clk`.
- Blank alignment with PIPE_DEPTH = 2, on line `DrawY` = 0:
  - `blank` rises on the edge where `DrawX` becomes 2 and falls where `DrawX` becomes 642.
  - `blank` stays 0 on every line with `DrawY` ≥ 482 that is observed in the delayed window.
  - Across the frame wrap, `blank` first rises when `DrawX` = 2 and `DrawY` = 0.
- Mid-frame reset: assert `Reset_n` = 0 asynchronously at `DrawX` = 700, `DrawY` = 490, while `hs` and `vs` are low.
  - `hs` and `vs` go to 1 before the next `Clk` edge.
  - After release, the first `hs` low begins 656 pixel periods later (plus PIPE_DEPTH).

Source files
------------

// File: rtl/vga_timing_gen_if.sv
// vga_if: raster outputs from the timing generator to the colour mapper and the VGA DAC
interface vga_if;
  logic       pixel_clk;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       hs;
  logic       vs;
  logic       blank;
  logic       sync;
  logic       frame_start;
  modport master (output pixel_clk, DrawX, DrawY, hs, vs, blank, sync, frame_start);
  modport slave  (input  pixel_clk, DrawX, DrawY, hs, vs, blank, sync, frame_start);
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 raster counters with sync/blank delayed to match the colour path
module vga_timing_gen #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int PIPE_DEPTH = 2
) (
  input  logic Clk,
  input  logic Reset_n,
  vga_if.master vga
);
  // With no delay one stage is still kept, so the strobes remain registered
  localparam int N = (PIPE_DEPTH == 0) ? 1 : PIPE_DEPTH;
  localparam logic [9:0] H_LAST = 10'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST = 10'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FP + V_SYNC);
  localparam logic [2:0] IDLE   = 3'b110;

  logic       r_pix;
  logic [9:0] r_x;
  logic [9:0] r_y;
  logic       r_fs;
  logic [2:0] r_pipe [N];
  logic       w_x_last;
  logic       w_y_last;
  logic [9:0] w_nx;
  logic [9:0] w_ny;
  logic [2:0] w_raw_in;

  // {hs, vs, blank} for one pixel position, sync strobes active-low
  function automatic logic [2:0] f_raw(input logic [9:0] x, input logic [9:0] y);
    return {~(x >= HS_BEG && x < HS_END), ~(y >= VS_BEG && y < VS_END), (x < H_VIS && y < V_VIS)};
  endfunction

  assign w_x_last = r_x == H_LAST;
  assign w_y_last = r_y == V_LAST;
  assign w_nx     = w_x_last ? 10'd0 : r_x + 10'd1;
  assign w_ny     = w_x_last ? (w_y_last ? 10'd0 : r_y + 10'd1) : r_y;
  // Zero delay decodes the pixel being entered; otherwise the pixel being left feeds the first stage
  assign w_raw_in = (PIPE_DEPTH == 0) ? f_raw(w_nx, w_ny) : f_raw(r_x, r_y);

  // Pixel-rate divider, raster counters, frame pulse and strobe delay line
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_pix <= 1'b0;
      r_x   <= '0;
      r_y   <= '0;
      r_fs  <= 1'b0;
      for (int i = 0; i < N; i++) r_pipe[i] <= IDLE;
    end else begin
      r_pix <= ~r_pix;
      r_fs  <= r_pix && w_nx == 10'd0 && w_ny == 10'd0;
      if (r_pix) begin
        r_x       <= w_nx;
        r_y       <= w_ny;
        r_pipe[0] <= w_raw_in;
        for (int i = 1; i < N; i++) r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign vga.pixel_clk   = r_pix;
  assign vga.DrawX       = r_x;
  assign vga.DrawY       = r_y;
  assign vga.hs          = r_pipe[N-1][2];
  assign vga.vs          = r_pipe[N-1][1];
  assign vga.blank       = r_pipe[N-1][0];
  assign vga.sync        = 1'b0;
  assign vga.frame_start = r_fs;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: random-reset stimulus checked against an arithmetic raster model
module tb_vga_timing_gen;
  typedef struct packed {int hv; int hfp; int hs; int hbp; int vv; int vfp; int vs; int vbp; int d;} cfg_t;
  localparam cfg_t CA = '{640, 16, 96, 48, 480, 10, 2, 33, 0};
  localparam cfg_t CB = '{640, 16, 96, 48, 480, 10, 2, 33, 2};
  localparam cfg_t CC = '{20, 4, 6, 5, 12, 2, 3, 4, 4};
  localparam cfg_t CD = '{20, 4, 6, 5, 12, 2, 3, 4, 1};

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  int k = 0;
  int n_chk = 0;
  int n_fail = 0;

  vga_if ia ();
  vga_if ib ();
  vga_if ic ();
  vga_if id ();

  vga_timing_gen #(.PIPE_DEPTH(CA.d)) u_a (.Clk(Clk), .Reset_n(Reset_n), .vga(ia));
  vga_timing_gen #(.PIPE_DEPTH(CB.d)) u_b (.Clk(Clk), .Reset_n(Reset_n), .vga(ib));
  vga_timing_gen #(.H_VISIBLE(CC.hv), .H_FP(CC.hfp), .H_SYNC(CC.hs), .H_BP(CC.hbp),
                   .V_VISIBLE(CC.vv), .V_FP(CC.vfp), .V_SYNC(CC.vs), .V_BP(CC.vbp),
                   .PIPE_DEPTH(CC.d)) u_c (.Clk(Clk), .Reset_n(Reset_n), .vga(ic));
  vga_timing_gen #(.H_VISIBLE(CD.hv), .H_FP(CD.hfp), .H_SYNC(CD.hs), .H_BP(CD.hbp),
                   .V_VISIBLE(CD.vv), .V_FP(CD.vfp), .V_SYNC(CD.vs), .V_BP(CD.vbp),
                   .PIPE_DEPTH(CD.d)) u_d (.Clk(Clk), .Reset_n(Reset_n), .vga(id));

  always #5 Clk = ~Clk;

  // k = Clk edges seen since reset was last released
  always @(posedge Clk or negedge Reset_n) k <= !Reset_n ? 0 : k + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t k=%0d)", tag, obs, exp, $time, k);
    end
  endtask

  // Expected {pixel_clk, DrawX, DrawY, hs, vs, blank, sync, frame_start} after k edges
  function automatic logic [25:0] model(input cfg_t c, input int kk);
    int ht, vt, p, q, qx, qy;
    logic h, v, b, f;
    ht = c.hv + c.hfp + c.hs + c.hbp;
    vt = c.vv + c.vfp + c.vs + c.vbp;
    p = kk / 2;
    q = p - c.d;
    h = 1'b1;
    v = 1'b1;
    b = 1'b0;
    if (p >= 1 && q >= 0) begin
      qx = q % ht;
      qy = (q / ht) % vt;
      h = !(qx >= c.hv + c.hfp && qx < c.hv + c.hfp + c.hs);
      v = !(qy >= c.vv + c.vfp && qy < c.vv + c.vfp + c.vs);
      b = qx < c.hv && qy < c.vv;
    end
    f = kk >= 2 && kk % 2 == 0 && p % (ht * vt) == 0;
    return {1'(kk % 2), 10'(p % ht), 10'((p / ht) % vt), h, v, b, 1'b0, f};
  endfunction

  int a_fall = -1, c_fs = -1;
  logic a_hs_q = 1'b1, b_bl_q = 1'b0, c_fs_q = 1'b0;

  // Whole-state comparison of every instance each cycle, plus edge-position checks
  always @(negedge Clk) begin
    chk("a_state", {6'd0, ia.pixel_clk, ia.DrawX, ia.DrawY, ia.hs, ia.vs, ia.blank, ia.sync, ia.frame_start}, {6'd0, model(CA, k)});
    chk("b_state", {6'd0, ib.pixel_clk, ib.DrawX, ib.DrawY, ib.hs, ib.vs, ib.blank, ib.sync, ib.frame_start}, {6'd0, model(CB, k)});
    chk("c_state", {6'd0, ic.pixel_clk, ic.DrawX, ic.DrawY, ic.hs, ic.vs, ic.blank, ic.sync, ic.frame_start}, {6'd0, model(CC, k)});
    chk("d_state", {6'd0, id.pixel_clk, id.DrawX, id.DrawY, id.hs, id.vs, id.blank, id.sync, id.frame_start}, {6'd0, model(CD, k)});
    if (!Reset_n) begin
      a_fall = -1;
      c_fs = -1;
    end else begin
      if (a_hs_q && !ia.hs) begin
        chk("hs_fall_x", 32'(ia.DrawX), 656);
        if (a_fall >= 0) chk("hs_period", k - a_fall, 1600);
        a_fall = k;
      end
      if (!a_hs_q && ia.hs) chk("hs_rise_x", 32'(ia.DrawX), 752);
      if (!b_bl_q && ib.blank) chk("blank_rise_x", 32'(ib.DrawX), 2);
      if (b_bl_q && !ib.blank) chk("blank_fall_x", 32'(ib.DrawX), 642);
      if (ic.frame_start) begin
        chk("fs_xy", {12'd0, ic.DrawX, ic.DrawY}, 0);
        if (c_fs >= 0) chk("fs_period", k - c_fs, 2 * 35 * 21);
        c_fs = k;
      end
      if (c_fs_q) chk("fs_width", 32'(ic.frame_start), 0);
    end
    a_hs_q = ia.hs;
    b_bl_q = ib.blank;
    c_fs_q = ic.frame_start;
  end

  task automatic release_rst;
    @(negedge Clk);
    #2 Reset_n = 1'b1;
  endtask

  task automatic assert_rst;
    @(posedge Clk);
    #($urandom_range(1, 4)) Reset_n = 1'b0;
    #1;
    chk("async_hs", 32'(ib.hs), 1);
    chk("async_vs", 32'(ic.vs), 1);
    chk("async_x", 32'(ia.DrawX), 0);
  endtask

  initial begin
    bit found;
    repeat (5) @(posedge Clk);
    release_rst();
    repeat (2) @(posedge Clk);
    #1 chk("x_after_2", 32'(ia.DrawX), 1);
    repeat (2) @(posedge Clk);
    #1 chk("x_after_4", 32'(ia.DrawX), 2);
    repeat (5000) @(posedge Clk);
    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      @(negedge Clk);
      found = !ic.hs && !ic.vs;
    end
    chk("mid_found", 32'(found), 1);
    #1 Reset_n = 1'b0;
    #1 chk("mid_hs", {30'd0, ic.hs, ic.vs}, 3);
    repeat (3) @(posedge Clk);
    release_rst();
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge Clk);
      found = !ic.hs;
    end
    chk("mid_hs_first", found ? k : -1, 2 * (CC.hv + CC.hfp + CC.d));
    for (int e = 0; e < 8; e++) begin
      repeat ($urandom_range(200, 4000)) @(posedge Clk);
      assert_rst();
      repeat ($urandom_range(1, 5)) @(posedge Clk);
      release_rst();
    end
    repeat (3500) @(posedge Clk);
    @(negedge Clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
